bist_resp_checker: RTL

Sequential, parametrised BIST response checker. It compares SRAM read data against expected data, one beat per valid cycle, within a start/end test window. It accumulates a saturating fail count, captures the first failing address and bit-difference, and reports done/pass to the BIST controller. It sits between the SRAM read port and the BIST controller FSM.

---
 rtl/bist_resp_checker_if.sv | 45 ++++
 rtl/bist_resp_checker.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/bist_resp_checker_if.sv
// Bus between the BIST controller / SRAM read port and the response checker.
// Optional macro BIST_CMP_MASK_EN adds the per-bit compare mask cmp_mask.
interface bist_resp_checker_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              test_end;
  logic              cmp_valid;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] act_data;
  logic [DATA_W-1:0] exp_data;
`ifdef BIST_CMP_MASK_EN
  logic [DATA_W-1:0] cmp_mask;
`endif
  logic              busy;
  logic              mismatch;
  logic              fail_sticky;
  logic [CNT_W-1:0]  fail_count;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [DATA_W-1:0] first_fail_diff;
  logic              done;
  logic              pass;

  // Controller / pattern side: drives beats, observes results.
  modport master (
    output start, test_end, cmp_valid, cmp_addr, act_data, exp_data,
`ifdef BIST_CMP_MASK_EN
    output cmp_mask,
`endif
    input  busy, mismatch, fail_sticky, fail_count, first_fail_addr,
    input  first_fail_diff, done, pass
  );

  // Checker side.
  modport slave (
    input  start, test_end, cmp_valid, cmp_addr, act_data, exp_data,
`ifdef BIST_CMP_MASK_EN
    input  cmp_mask,
`endif
    output busy, mismatch, fail_sticky, fail_count, first_fail_addr,
    output first_fail_diff, done, pass
  );
endinterface

// File: rtl/bist_resp_checker.sv
// BIST response checker: compares SRAM read beats against expected data inside
// a start/test_end window, keeps a saturating fail count, captures the first
// failing address and bit difference, and reports done/pass.
// Optional macro BIST_CMP_MASK_EN: masked bits (cmp_mask=1) are not compared.
module bist_resp_checker #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  bist_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Bit difference of one beat with the excluded bits forced to zero.
  function automatic logic [DATA_W-1:0] beat_diff(
    input logic [DATA_W-1:0] act,
    input logic [DATA_W-1:0] exp,
    input logic [DATA_W-1:0] mask
  );
    return (act ^ exp) & ~mask;
  endfunction

  state_t            state_r;
  logic              busy_r;
  logic              done_r;
  logic              pass_r;

  // Compare stage: stg_hit_r is a failing accepted beat and doubles as mismatch.
  logic              stg_hit_r;
  logic [ADDR_W-1:0] stg_addr_r;
  logic [DATA_W-1:0] stg_diff_r;

  logic              fail_sticky_r;
  logic [CNT_W-1:0]  fail_count_r;
  logic [ADDR_W-1:0] first_addr_r;
  logic [DATA_W-1:0] first_diff_r;

  logic [DATA_W-1:0] mask_s;
  logic [DATA_W-1:0] diff_s;
  logic              accept_s;
  logic [CNT_W-1:0]  cnt_next_s;

  // Beat qualification and compare; a beat coincident with start is dropped.
  always_comb begin
`ifdef BIST_CMP_MASK_EN
    mask_s = bus.cmp_mask;
`else
    mask_s = {DATA_W{1'b0}};
`endif
    diff_s   = beat_diff(bus.act_data, bus.exp_data, mask_s);
    accept_s = bus.cmp_valid && (state_r == ST_ACTIVE) && !bus.start;
  end

  // Fail count after retiring the staged beat, saturating at all-ones.
  always_comb begin
    cnt_next_s = fail_count_r;
    if (stg_hit_r && (fail_count_r != CNT_MAX)) begin
      cnt_next_s = fail_count_r + CNT_W'(1'b1);
    end else begin
      cnt_next_s = fail_count_r;
    end
  end

  // Test-window FSM with registered busy/done/pass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else if (bus.start) begin
      state_r <= ST_ACTIVE;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          busy_r <= 1'b0;
        end
        ST_ACTIVE: begin
          if (bus.test_end) begin
            state_r <= ST_DRAIN;
          end
          busy_r <= 1'b1;
        end
        ST_DRAIN: begin
          // The last beat retires this cycle, so cnt_next_s is final.
          state_r <= ST_DONE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          pass_r  <= (cnt_next_s == {CNT_W{1'b0}});
        end
        ST_DONE: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          pass_r  <= 1'b0;
        end
      endcase
    end
  end

  // Compare stage register and statistics accumulation from that stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_hit_r     <= 1'b0;
      stg_addr_r    <= {ADDR_W{1'b0}};
      stg_diff_r    <= {DATA_W{1'b0}};
      fail_sticky_r <= 1'b0;
      fail_count_r  <= {CNT_W{1'b0}};
      first_addr_r  <= {ADDR_W{1'b0}};
      first_diff_r  <= {DATA_W{1'b0}};
    end else if (bus.start) begin
      stg_hit_r     <= 1'b0;
      stg_addr_r    <= {ADDR_W{1'b0}};
      stg_diff_r    <= {DATA_W{1'b0}};
      fail_sticky_r <= 1'b0;
      fail_count_r  <= {CNT_W{1'b0}};
      first_addr_r  <= {ADDR_W{1'b0}};
      first_diff_r  <= {DATA_W{1'b0}};
    end else begin
      stg_hit_r    <= accept_s && (diff_s != {DATA_W{1'b0}});
      stg_addr_r   <= bus.cmp_addr;
      stg_diff_r   <= diff_s;
      fail_count_r <= cnt_next_s;
      if (stg_hit_r) begin
        fail_sticky_r <= 1'b1;
        if (!fail_sticky_r) begin
          first_addr_r <= stg_addr_r;
          first_diff_r <= stg_diff_r;
        end
      end
    end
  end

  assign bus.busy            = busy_r;
  assign bus.mismatch        = stg_hit_r;
  assign bus.fail_sticky     = fail_sticky_r;
  assign bus.fail_count      = fail_count_r;
  assign bus.first_fail_addr = first_addr_r;
  assign bus.first_fail_diff = first_diff_r;
  assign bus.done            = done_r;
  assign bus.pass            = pass_r;

endmodule
